elbeth_memory_responder: RTL and testbench

ELBETH_MEMORY_RESPONDER -- requirements
Module: elbeth_memory_responder

---
 rtl/elbeth_memory_responder_if.sv | 33 +++
 rtl/elbeth_memory_responder.sv | 162 ++++++++++++++++
 tb/tb_elbeth_memory_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/elbeth_memory_responder_if.sv
// Two-port request/response bundle for elbeth_memory_responder.
// The slave modport is the responder side and the master modport is the requester side.
interface elbeth_memory_responder_if;
  logic        amem_en;
  logic [11:0] amem_addr;
  logic [31:0] amem_out_data;
  logic [3:0]  amem_rw;
  logic [31:0] amem_in_data;
  logic        amem_ready;
  logic        amem_error;

  logic        bmem_en;
  logic [11:0] bmem_addr;
  logic [31:0] bmem_out_data;
  logic [3:0]  bmem_rw;
  logic [31:0] bmem_in_data;
  logic        bmem_ready;
  logic        bmem_error;

  modport slave (
    input  amem_en, amem_addr, amem_out_data, amem_rw,
    output amem_in_data, amem_ready, amem_error,
    input  bmem_en, bmem_addr, bmem_out_data, bmem_rw,
    output bmem_in_data, bmem_ready, bmem_error
  );

  modport master (
    output amem_en, amem_addr, amem_out_data, amem_rw,
    input  amem_in_data, amem_ready, amem_error,
    output bmem_en, bmem_addr, bmem_out_data, bmem_rw,
    input  bmem_in_data, bmem_ready, bmem_error
  );
endinterface

// File: rtl/elbeth_memory_responder.sv
// Dual-port word memory with per-port IDLE/BUSY/DONE wait-state FSMs and byte-strobed writes.
// Define ELBETH_MEM_RANGE_CHECK_EN to flag out-of-range addresses; otherwise addresses wrap modulo MEM_WORDS.
module elbeth_memory_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  elbeth_memory_responder_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int         AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  logic [31:0] mem_q [MEM_WORDS];

  logic        req_en    [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_rw    [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_ready [2];
  logic        rsp_error [2];

  logic          wr_en   [2];
  logic [AW-1:0] wr_idx  [2];
  logic [31:0]   wr_data [2];
  logic [3:0]    wr_strb [2];

  assign req_en[0]    = bus.amem_en;
  assign req_addr[0]  = bus.amem_addr;
  assign req_wdata[0] = bus.amem_out_data;
  assign req_rw[0]    = bus.amem_rw;
  assign req_en[1]    = bus.bmem_en;
  assign req_addr[1]  = bus.bmem_addr;
  assign req_wdata[1] = bus.bmem_out_data;
  assign req_rw[1]    = bus.bmem_rw;

  assign bus.amem_in_data = rsp_data[0];
  assign bus.amem_ready   = rsp_ready[0];
  assign bus.amem_error   = rsp_error[0];
  assign bus.bmem_in_data = rsp_data[1];
  assign bus.bmem_ready   = rsp_ready[1];
  assign bus.bmem_error   = rsp_error[1];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [1:0]    state_q, state_d;
      logic [3:0]    cnt_q, cnt_d;
      logic [11:0]   addr_q;
      logic [31:0]   wdata_q;
      logic [3:0]    rw_q;
      logic [31:0]   data_q;
      logic          ready_q;
      logic          error_q;
      logic [11:0]   acc_addr;
      logic [31:0]   acc_wdata;
      logic [3:0]    acc_rw;
      logic [AW-1:0] acc_idx;
      logic          acc_oob;
      logic          access;
      logic [31:0]   merged;

      // With zero wait states the access happens on the capture edge, so use the live request.
      assign acc_addr  = (LATENCY == 0) ? req_addr[gi]  : addr_q;
      assign acc_wdata = (LATENCY == 0) ? req_wdata[gi] : wdata_q;
      assign acc_rw    = (LATENCY == 0) ? req_rw[gi]    : rw_q;
      assign access    = (LATENCY == 0) ? (state_q == ST_IDLE && req_en[gi])
                                        : (state_q == ST_BUSY && req_en[gi] && cnt_q == 4'd0);

`ifdef ELBETH_MEM_RANGE_CHECK_EN
      assign acc_oob = ({20'd0, acc_addr} >= 32'(MEM_WORDS));
      assign acc_idx = AW'({20'd0, acc_addr});
`else
      assign acc_oob = 1'b0;
      assign acc_idx = AW'({20'd0, acc_addr} % 32'(MEM_WORDS));
`endif

      assign merged = merge_bytes(mem_q[acc_idx], acc_wdata, acc_rw);

      assign wr_en[gi]   = access && !acc_oob && (|acc_rw) && rst_n;
      assign wr_idx[gi]  = acc_idx;
      assign wr_data[gi] = acc_wdata;
      assign wr_strb[gi] = acc_rw;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_IDLE: if (req_en[gi]) begin
            cnt_d   = LAT_CNT;
            state_d = (LATENCY == 0) ? ST_DONE : ST_BUSY;
          end
          ST_BUSY: begin
            if (!req_en[gi]) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          data_q  <= 32'h0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          ready_q <= access;
          error_q <= access && acc_oob;
          if (access) data_q <= acc_oob ? 32'h0 : merged;
          if (state_q == ST_IDLE && req_en[gi]) begin
            addr_q  <= req_addr[gi];
            wdata_q <= req_wdata[gi];
            rw_q    <= req_rw[gi];
          end
        end
      end

      assign rsp_data[gi]  = data_q;
      assign rsp_ready[gi] = ready_q;
      assign rsp_error[gi] = error_q;
    end
  endgenerate

  // Port B is applied last so its bytes win where both ports strobe the same word.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[p][b]) mem_q[wr_idx[p]][8*b +: 8] <= wr_data[p][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_elbeth_memory_responder.sv
// Directed bench: LATENCY=1 instance for data paths, LATENCY=3 instance for abort and reset.
module tb_elbeth_memory_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  elbeth_memory_responder_if bus1();
  elbeth_memory_responder_if bus3();

  elbeth_memory_responder #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  elbeth_memory_responder #(.MEM_WORDS(1024), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // One transaction on dut1; cycles counted from the capture edge (ready expected at +2).
  task automatic xfer(input bit a_on, input logic [11:0] a_addr, input logic [31:0] a_wd, input logic [3:0] a_rw,
                      input bit b_on, input logic [11:0] b_addr, input logic [31:0] b_wd, input logic [3:0] b_rw,
                      output logic [31:0] a_rd, output logic a_err, output int a_cyc,
                      output logic [31:0] b_rd, output logic b_err, output int b_cyc);
    @(posedge clk); #1;
    bus1.amem_en = a_on; bus1.amem_addr = a_addr; bus1.amem_out_data = a_wd; bus1.amem_rw = a_rw;
    bus1.bmem_en = b_on; bus1.bmem_addr = b_addr; bus1.bmem_out_data = b_wd; bus1.bmem_rw = b_rw;
    a_cyc = -1; b_cyc = -1; a_rd = 'x; b_rd = 'x; a_err = 1'bx; b_err = 1'bx;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (a_on && a_cyc < 0 && bus1.amem_ready) begin
        a_cyc = c; a_rd = bus1.amem_in_data; a_err = bus1.amem_error; bus1.amem_en = 1'b0;
      end
      if (b_on && b_cyc < 0 && bus1.bmem_ready) begin
        b_cyc = c; b_rd = bus1.bmem_in_data; b_err = bus1.bmem_error; bus1.bmem_en = 1'b0;
      end
      if ((!a_on || a_cyc >= 0) && (!b_on || b_cyc >= 0)) break;
    end
    bus1.amem_en = 1'b0; bus1.bmem_en = 1'b0;
    $display("xfer A(%0b @%h rw=%h wd=%h -> %h err=%b cyc=%0d) B(%0b @%h rw=%h wd=%h -> %h err=%b cyc=%0d)",
             a_on, a_addr, a_rw, a_wd, a_rd, a_err, a_cyc, b_on, b_addr, b_rw, b_wd, b_rd, b_err, b_cyc);
  endtask

  // Port A transaction on dut3; cycles counted from the capture edge (ready expected at +4).
  task automatic xfer3(input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] rw,
                       output logic [31:0] rd, output int cyc);
    @(posedge clk); #1;
    bus3.amem_en = 1'b1; bus3.amem_addr = addr; bus3.amem_out_data = wd; bus3.amem_rw = rw;
    cyc = -1; rd = 'x;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus3.amem_ready) begin
        cyc = c; rd = bus3.amem_in_data; bus3.amem_en = 1'b0;
        break;
      end
    end
    bus3.amem_en = 1'b0;
    $display("xfer3 A @%h rw=%h wd=%h -> %h cyc=%0d", addr, rw, wd, rd, cyc);
  endtask

  task automatic test_reset();
    bus1.amem_en = 0; bus1.amem_addr = 0; bus1.amem_out_data = 0; bus1.amem_rw = 0;
    bus1.bmem_en = 0; bus1.bmem_addr = 0; bus1.bmem_out_data = 0; bus1.bmem_rw = 0;
    bus3.amem_en = 0; bus3.amem_addr = 0; bus3.amem_out_data = 0; bus3.amem_rw = 0;
    bus3.bmem_en = 0; bus3.bmem_addr = 0; bus3.bmem_out_data = 0; bus3.bmem_rw = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus1.amem_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready got %b want 0", bus1.amem_ready); end
    n_vec++; if (bus1.amem_error !== 1'b0) begin n_err++; $display("FAIL reset_a_error got %b want 0", bus1.amem_error); end
    n_vec++; if (bus1.amem_in_data !== 32'h0) begin n_err++; $display("FAIL reset_a_data got %h want 0", bus1.amem_in_data); end
    n_vec++; if (bus1.bmem_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready got %b want 0", bus1.bmem_ready); end
    n_vec++; if (bus1.bmem_in_data !== 32'h0) begin n_err++; $display("FAIL reset_b_data got %h want 0", bus1.bmem_in_data); end
    n_vec++; if (bus3.amem_in_data !== 32'h0) begin n_err++; $display("FAIL reset_dut3_data got %h want 0", bus3.amem_in_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] ard, brd; logic aerr, berr; int acyc, bcyc;
    xfer(1, 12'd5, 32'hDEADBEEF, 4'hF, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (acyc !== 2) begin n_err++; $display("FAIL wr_latency got %0d want 2", acyc); end
    n_vec++; if (ard !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_merged got %h want deadbeef", ard); end
    n_vec++; if (aerr !== 1'b0) begin n_err++; $display("FAIL wr_error got %b want 0", aerr); end
    @(posedge clk); #1;
    n_vec++; if (bus1.amem_ready !== 1'b0) begin n_err++; $display("FAIL ready_one_cycle got %b want 0", bus1.amem_ready); end
    n_vec++; if (bus1.amem_in_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL data_hold got %h want deadbeef", bus1.amem_in_data); end
    xfer(1, 12'd5, 32'h0, 4'h0, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (acyc !== 2) begin n_err++; $display("FAIL rd_latency got %0d want 2", acyc); end
    n_vec++; if (ard !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", ard); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] ard, brd; logic aerr, berr; int acyc, bcyc;
    xfer(1, 12'd7, 32'h11223344, 4'hF, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h11223344) begin n_err++; $display("FAIL strb_full got %h want 11223344", ard); end
    xfer(1, 12'd7, 32'hAABBCCDD, 4'b0101, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h11BB33DD) begin n_err++; $display("FAIL strb_merged got %h want 11bb33dd", ard); end
    xfer(0, 12'd0, 32'h0, 4'h0, 1, 12'd7, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (brd !== 32'h11BB33DD) begin n_err++; $display("FAIL strb_readback_b got %h want 11bb33dd", brd); end
  endtask

  task automatic test_range();
    logic [31:0] ard, brd; logic aerr, berr; int acyc, bcyc;
    xfer(1, 12'd0, 32'hCAFEF00D, 4'hF, 1, 12'h3FF, 32'h5A5A0001, 4'hF, ard, aerr, acyc, brd, berr, bcyc);
    xfer(1, 12'h3FF, 32'h0, 4'h0, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h5A5A0001) begin n_err++; $display("FAIL range_last_word got %h want 5a5a0001", ard); end
    n_vec++; if (aerr !== 1'b0) begin n_err++; $display("FAIL range_last_err got %b want 0", aerr); end
    xfer(1, 12'h400, 32'h0, 4'h0, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (acyc !== 2) begin n_err++; $display("FAIL range_oob_latency got %0d want 2", acyc); end
`ifdef ELBETH_MEM_RANGE_CHECK_EN
    n_vec++; if (aerr !== 1'b1) begin n_err++; $display("FAIL range_oob_err got %b want 1", aerr); end
    n_vec++; if (ard !== 32'h0) begin n_err++; $display("FAIL range_oob_data got %h want 0", ard); end
`else
    n_vec++; if (aerr !== 1'b0) begin n_err++; $display("FAIL range_wrap_err got %b want 0", aerr); end
    n_vec++; if (ard !== 32'hCAFEF00D) begin n_err++; $display("FAIL range_wrap_data got %h want cafef00d", ard); end
`endif
  endtask

  task automatic test_concurrent();
    logic [31:0] ard, brd; logic aerr, berr; int acyc, bcyc;
    xfer(1, 12'd3, 32'h1, 4'hF, 1, 12'd3, 32'h2, 4'hF, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (bcyc !== 2) begin n_err++; $display("FAIL conc_b_latency got %0d want 2", bcyc); end
    xfer(1, 12'd3, 32'h0, 4'h0, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h2) begin n_err++; $display("FAIL conc_b_wins got %h want 00000002", ard); end
    xfer(1, 12'd9, 32'h0, 4'hF, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    xfer(1, 12'd9, 32'hAAAAAAAA, 4'b0011, 1, 12'd9, 32'hBBBBBBBB, 4'b0110, ard, aerr, acyc, brd, berr, bcyc);
    xfer(1, 12'd9, 32'h0, 4'h0, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h00BBBBAA) begin n_err++; $display("FAIL conc_partial got %h want 00bbbbaa", ard); end
    xfer(1, 12'd3, 32'h0, 4'h0, 1, 12'd3, 32'h33, 4'hF, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h2) begin n_err++; $display("FAIL conc_read_old got %h want 00000002", ard); end
    xfer(1, 12'd3, 32'h0, 4'h0, 0, 12'd0, 32'h0, 4'h0, ard, aerr, acyc, brd, berr, bcyc);
    n_vec++; if (ard !== 32'h33) begin n_err++; $display("FAIL conc_read_new got %h want 00000033", ard); end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; int cyc; logic seen;
    xfer3(12'd4, 32'h44, 4'hF, rd, cyc);
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL lat3_latency got %0d want 4", cyc); end
    // Abort: drop en one cycle into BUSY.
    @(posedge clk); #1;
    bus3.amem_en = 1'b1; bus3.amem_addr = 12'd4; bus3.amem_out_data = 32'h99; bus3.amem_rw = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus3.amem_en = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | bus3.amem_ready | bus3.amem_error; end
    $display("abort dut3 @004 wd=00000099 ready_or_error_seen=%b", seen);
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_ready got %b want 0", seen); end
    xfer3(12'd4, 32'h0, 4'h0, rd, cyc);
    n_vec++; if (rd !== 32'h44) begin n_err++; $display("FAIL abort_mem_kept got %h want 00000044", rd); end
    // Reset one cycle into BUSY.
    @(posedge clk); #1;
    bus3.amem_en = 1'b1; bus3.amem_addr = 12'd4; bus3.amem_out_data = 32'h77; bus3.amem_rw = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus3.amem_en = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen = seen | bus3.amem_ready; end
    $display("reset mid-busy dut3 @004 wd=00000077 data=%h ready_seen=%b", bus3.amem_in_data, seen);
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_no_ready got %b want 0", seen); end
    n_vec++; if (bus3.amem_in_data !== 32'h0) begin n_err++; $display("FAIL rst_data_clear got %h want 0", bus3.amem_in_data); end
    n_vec++; if (bus3.amem_error !== 1'b0) begin n_err++; $display("FAIL rst_error_clear got %b want 0", bus3.amem_error); end
    rst_n = 1'b1;
    xfer3(12'd4, 32'h0, 4'h0, rd, cyc);
    n_vec++; if (rd !== 32'h44) begin n_err++; $display("FAIL rst_mem_kept got %h want 00000044", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_range();
    test_concurrent();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
